// File: rtl/iq_pair_sequencer.sv
// iq_pair_sequencer: walks the pair mux select over one frame and streams each registered I/Q pair downstream
module iq_pair_sequencer #(
  parameter int DATA_W  = 9,
  parameter int N_PAIRS = 5,
  parameter int SEL_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_a,
  input  logic [DATA_W-1:0] mux_b,
  output logic [DATA_W-1:0] pair_i,
  output logic [DATA_W-1:0] pair_q,
  output logic [SEL_W-1:0]  pair_idx,
  output logic              pair_last,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              frame_done,
  output logic              overrun,
  input  logic              overrun_clr
);
  typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic done_n;
  logic hs;
  logic last;
  always_comb begin
    state_n = state;
    sel_n   = mux_sel;
    done_n  = 1'b0;
    hs      = pair_valid && pair_ready;
    last    = mux_sel == SEL_W'(N_PAIRS - 1);
    case (state)
      IDLE: begin
        state_n = frame_valid ? LOAD : IDLE;
        sel_n   = '0;
      end
      LOAD: state_n = OUT;
      OUT: if (hs) begin
        state_n = last ? IDLE : LOAD;
        sel_n   = last ? '0 : mux_sel + SEL_W'(1);
        done_n  = last;
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mux_sel     <= '0;
      frame_ready <= 1'b1;
      pair_valid  <= 1'b0;
      frame_done  <= 1'b0;
      pair_i      <= '0;
      pair_q      <= '0;
      pair_idx    <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      mux_sel     <= sel_n;
      frame_ready <= state_n == IDLE;
      pair_valid  <= state_n == OUT;
      frame_done  <= done_n;
      overrun     <= (frame_valid && state != IDLE) || (overrun && !overrun_clr);
      if (state == LOAD) begin
        pair_i   <= mux_a;
        pair_q   <= mux_b;
        pair_idx <= mux_sel;
      end
    end
  end
  assign pair_last = pair_valid && pair_idx == SEL_W'(N_PAIRS - 1);
endmodule

// File: tb/tb_iq_pair_sequencer.sv
// tb_iq_pair_sequencer: table-driven and scenario checks of the pair sequencer against a pair scoreboard
module tb_iq_pair_sequencer;
  localparam int DW = 9;
  localparam int NP = 5;
  localparam int SW = 3;
  typedef struct packed {
    logic          fr;
    logic [SW-1:0] sel;
    logic          pv;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic [SW-1:0] idx;
    logic          last;
    logic          done;
    logic          ov;
  } out_t;
  typedef struct {
    logic rst;
    logic fv;
    logic pr;
    logic clr;
    out_t exp;
  } vec_t;
  typedef struct packed {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic [SW-1:0] idx;
  } pair_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_valid = 1'b0;
  logic pair_ready = 1'b0;
  logic overrun_clr = 1'b0;
  logic frame_ready, pair_last, pair_valid, frame_done, overrun;
  logic [SW-1:0] mux_sel, pair_idx;
  logic [DW-1:0] mux_a, mux_b, pair_i, pair_q;
  logic [DW-1:0] din_i [NP];
  logic [DW-1:0] din_q [NP];
  pair_t exp_q [$];
  pair_t mon_e;
  vec_t tab [13];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  logic rnd = 1'b0;
  always #5 clk = ~clk;
  assign mux_a = mux_sel < SW'(NP) ? din_i[mux_sel] : '0;
  assign mux_b = mux_sel < SW'(NP) ? din_q[mux_sel] : '0;
  iq_pair_sequencer #(.DATA_W(DW), .N_PAIRS(NP), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .mux_sel(mux_sel), .mux_a(mux_a), .mux_b(mux_b), .pair_i(pair_i), .pair_q(pair_q),
    .pair_idx(pair_idx), .pair_last(pair_last), .pair_valid(pair_valid),
    .pair_ready(pair_ready), .frame_done(frame_done), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );
  function automatic out_t o(logic fr, logic [SW-1:0] sel, logic pv, logic [DW-1:0] i, logic [DW-1:0] q,
                             logic [SW-1:0] idx, logic last, logic done, logic ov);
    return '{fr, sel, pv, i, q, idx, last, done, ov};
  endfunction
  function automatic vec_t row(logic r, logic fv, logic pr, logic clr, out_t e);
    vec_t v;
    v.rst = r;
    v.fv = fv;
    v.pr = pr;
    v.clr = clr;
    v.exp = e;
    return v;
  endfunction
  function automatic out_t obs();
    return '{frame_ready, mux_sel, pair_valid, pair_i, pair_q, pair_idx, pair_last, frame_done, overrun};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ramp();
    for (int k = 0; k < NP; k++) begin
      din_i[k] = DW'(k * 10);
      din_q[k] = DW'(k * 10 + 1);
    end
  endtask
  task automatic push_frame();
    for (int k = 0; k < NP; k++) exp_q.push_back('{din_i[k], din_q[k], SW'(k)});
  endtask
  task automatic start_frame();
    push_frame();
    chk("frame_ready_at_start", frame_ready, 1);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask
  task automatic wait_done(string name);
    for (int n = 0; n < 200 && !frame_done; n++) begin
      if (rnd) pair_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk(name, frame_done, 1);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("mux_sel_range", mux_sel < SW'(NP), 1);
      if (frame_done) done_cnt++;
      if (pair_valid && pair_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pair", {pair_i, pair_q, pair_idx}, 32'hffff_ffff);
        else begin
          mon_e = exp_q.pop_front();
          chk("pair_stream", {pair_i, pair_q, pair_idx}, mon_e);
        end
      end
    end
  end
  initial begin
    tab[0]  = row(1, 0, 1, 0, o(1, 0, 0,  0,  0, 0, 0, 0, 0));
    tab[1]  = row(0, 1, 1, 0, o(0, 0, 0,  0,  0, 0, 0, 0, 0));
    tab[2]  = row(0, 0, 1, 0, o(0, 0, 1,  0,  1, 0, 0, 0, 0));
    tab[3]  = row(0, 0, 1, 0, o(0, 1, 0,  0,  1, 0, 0, 0, 0));
    tab[4]  = row(0, 0, 1, 0, o(0, 1, 1, 10, 11, 1, 0, 0, 0));
    tab[5]  = row(0, 0, 1, 0, o(0, 2, 0, 10, 11, 1, 0, 0, 0));
    tab[6]  = row(0, 0, 1, 0, o(0, 2, 1, 20, 21, 2, 0, 0, 0));
    tab[7]  = row(0, 0, 1, 0, o(0, 3, 0, 20, 21, 2, 0, 0, 0));
    tab[8]  = row(0, 0, 1, 0, o(0, 3, 1, 30, 31, 3, 0, 0, 0));
    tab[9]  = row(0, 0, 1, 0, o(0, 4, 0, 30, 31, 3, 0, 0, 0));
    tab[10] = row(0, 0, 1, 0, o(0, 4, 1, 40, 41, 4, 1, 0, 0));
    tab[11] = row(0, 0, 1, 0, o(1, 0, 0, 40, 41, 4, 0, 1, 0));
    tab[12] = row(0, 0, 1, 0, o(1, 0, 0, 40, 41, 4, 0, 0, 0));
    set_ramp();
    push_frame();
    for (int r = 0; r < 13; r++) begin
      rst = tab[r].rst;
      frame_valid = tab[r].fv;
      pair_ready = tab[r].pr;
      overrun_clr = tab[r].clr;
      tick();
      chk($sformatf("table_row%0d", r), obs(), tab[r].exp);
    end
    frame_valid = 1'b0;
    chk("table_queue_empty", exp_q.size(), 0);
    chk("table_done_count", done_cnt, 1);
    d0 = done_cnt;
    start_frame();
    for (int n = 0; n < 20 && !(pair_valid && pair_idx == 2); n++) tick();
    chk("bp_reach_pair2", pair_valid && pair_idx == 2, 1);
    pair_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_hold", {pair_valid, pair_i, pair_q, pair_idx, mux_sel}, {1'b1, 9'd20, 9'd21, 3'd2, 3'd2});
    end
    pair_ready = 1'b1;
    wait_done("bp_done");
    tick();
    chk("bp_done_count", done_cnt, d0 + 1);
    chk("bp_queue_empty", exp_q.size(), 0);
    start_frame();
    for (int n = 0; n < 20 && !(pair_valid && pair_idx == 1); n++) tick();
    chk("ov_reach_pair1", pair_valid && pair_idx == 1, 1);
    chk("ov_clear_before", overrun, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("ov_set", overrun, 1);
    d0 = done_cnt;
    wait_done("ov_done");
    tick();
    chk("ov_sticky", overrun, 1);
    chk("ov_frame_complete", done_cnt, d0 + 1);
    chk("ov_queue_empty", exp_q.size(), 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ov_cleared", overrun, 0);
    start_frame();
    frame_valid = 1'b1;
    overrun_clr = 1'b1;
    tick();
    frame_valid = 1'b0;
    overrun_clr = 1'b0;
    chk("ov_set_wins", overrun, 1);
    wait_done("ov2_done");
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    start_frame();
    for (int n = 0; n < 20 && !(pair_valid && pair_idx == 3); n++) tick();
    chk("rst_reach_pair3", pair_valid && pair_idx == 3, 1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_mid_outputs", obs(), o(1, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    chk("rst_no_done", done_cnt, d0);
    start_frame();
    wait_done("rst_new_done");
    tick();
    chk("rst_new_queue_empty", exp_q.size(), 0);
    chk("rst_new_done_count", done_cnt, d0 + 1);
    d0 = done_cnt;
    start_frame();
    wait_done("b2b_first_done");
    start_frame();
    chk("b2b_accept", {frame_ready, mux_sel, pair_valid}, {1'b0, 3'd0, 1'b0});
    tick();
    chk("b2b_first_pair", {pair_valid, pair_idx, pair_i, pair_q}, {1'b1, 3'd0, 9'd0, 9'd1});
    wait_done("b2b_second_done");
    tick();
    chk("b2b_done_count", done_cnt, d0 + 2);
    chk("b2b_queue_empty", exp_q.size(), 0);
    rnd = 1'b1;
    d0 = done_cnt;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < NP; k++) begin
        din_i[k] = DW'($urandom_range(0, 511));
        din_q[k] = DW'($urandom_range(0, 511));
      end
      start_frame();
      wait_done("rand_done");
    end
    tick();
    chk("rand_done_count", done_cnt, d0 + 100);
    chk("rand_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
